// File: rtl/vga_reg_display_if.sv
// Video-side bundle of vga_reg_display: value capture inputs plus the registered
// VGA outputs and the pixel/frame strobes.
interface vga_reg_display_if #(
  parameter int N = 8
);
  logic [N-1:0] value;
  logic         value_valid;
  logic         pix_en;
  logic         hsync;
  logic         vsync;
  logic [7:0]   red;
  logic [7:0]   green;
  logic [7:0]   blue;
  logic         active;
  logic         frame_start;

  modport master (
    output value, value_valid,
    input  pix_en, hsync, vsync, red, green, blue, active, frame_start
  );

  modport slave (
    input  value, value_valid,
    output pix_en, hsync, vsync, red, green, blue, active, frame_start
  );
endinterface

// File: rtl/vga_reg_display.sv
// Parametrised VGA timing generator rendering an N-bit register as N vertical bars,
// with the displayed value reloaded once per frame so the picture never tears.
module vga_reg_display #(
  parameter int   N        = 8,
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input logic              fastclk,
  input logic              reset,
  vga_reg_display_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW      = (N > 1) ? $clog2(N) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_BAR    = HW'(H_ACTIVE / N);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [N-1:0]  pending;
  logic [N-1:0]  shown;
  logic [N-1:0]  shown_rev;
  logic [HW-1:0] bar;
  logic          pix_en;
  logic          line_end;
  logic          frame_end;
  logic          vis;
  logic          hs_win;
  logic          vs_win;
  logic          bit_on;
  logic [7:0]    level;
  logic          hsync_r;
  logic          vsync_r;
  logic          active_r;
  logic [7:0]    rgb_r;

  always_comb begin
    pix_en    = (div == DIV_LAST);
    line_end  = (hcnt == H_LAST);
    frame_end = pix_en && line_end && (vcnt == V_LAST);
    vis       = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_win    = (hcnt >= H_SS) && (hcnt < H_SE);
    vs_win    = (vcnt >= V_SS) && (vcnt < V_SE);
    // Bar 0 is leftmost and carries the MSB, so index a bit-reversed copy.
    shown_rev = '0;
    for (int unsigned i = 0; i < N; i++) begin
      shown_rev[i] = shown[N-1-i];
    end
    bar    = hcnt / H_BAR;
    bit_on = shown_rev[bar[IW-1:0]];
    if (!vis) begin
      level = 8'h00;
    end else if (bit_on) begin
      level = 8'hFF;
    end else begin
      level = 8'h20;
    end
  end

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      div      <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      pending  <= '0;
      shown    <= '0;
      hsync_r  <= ~SYNC_POL;
      vsync_r  <= ~SYNC_POL;
      active_r <= 1'b0;
      rgb_r    <= '0;
    end else begin
      div <= pix_en ? '0 : div + 1'b1;
      if (bus.value_valid) begin
        pending <= bus.value;
      end
      if (pix_en) begin
        hsync_r  <= hs_win ? SYNC_POL : ~SYNC_POL;
        vsync_r  <= vs_win ? SYNC_POL : ~SYNC_POL;
        active_r <= vis;
        rgb_r    <= level;
        hcnt     <= line_end ? '0 : hcnt + 1'b1;
        if (line_end) begin
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
        // Reload on the last pixel strobe so pixel (0,0) already sees the new value.
        if (frame_end) begin
          shown <= pending;
        end
      end
    end
  end

  assign bus.pix_en      = pix_en;
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.red         = rgb_r;
  assign bus.green       = rgb_r;
  assign bus.blue        = rgb_r;
  assign bus.active      = active_r;
  assign bus.frame_start = frame_end;
endmodule

// File: tb/tb_vga_reg_display.sv
// Bench for vga_reg_display: two small instances (div 2 active-low, div 1 active-high)
// compared every cycle against a cycle-count model, plus table-driven row checks.
module tb_vga_reg_display;
  localparam int N     = 4;
  localparam int HA    = 8;
  localparam int HFP   = 2;
  localparam int HS    = 2;
  localparam int HBP   = 2;
  localparam int VA    = 4;
  localparam int VFP   = 1;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] value = '0;
  logic vv = 1'b0;
  logic chk_on = 1'b0;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_reg_display_if #(.N(N)) ifa ();
  vga_reg_display_if #(.N(N)) ifb ();
  assign ifa.value       = value;
  assign ifa.value_valid = vv;
  assign ifb.value       = value;
  assign ifb.value_valid = vv;

  vga_reg_display #(
    .N(N), .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut_a (.fastclk(clk), .reset(reset), .bus(ifa));

  vga_reg_display #(
    .N(N), .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
  ) dut_b (.fastclk(clk), .reset(reset), .bus(ifb));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset release, pending value, and value shown in each frame.
  int unsigned e [2];
  logic [N-1:0] pend [2];
  logic [N-1:0] fval [2][64];

  function automatic int unsigned dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic fs_exp(input int unsigned ee, input int unsigned d);
    return ((ee % d) == d - 1) && (((ee / d) % FRAME) == FRAME - 1);
  endfunction

  function automatic int unsigned next_frame(input int unsigned ee, input int unsigned d);
    return ((ee / d) / FRAME + 1) % 64;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e[0] <= 0;
      e[1] <= 0;
      pend[0] <= '0;
      pend[1] <= '0;
      fval[0][0] <= '0;
      fval[1][0] <= '0;
    end else begin
      if (fs_exp(e[0], dv(0))) fval[0][next_frame(e[0], dv(0))] <= pend[0];
      if (fs_exp(e[1], dv(1))) fval[1][next_frame(e[1], dv(1))] <= pend[1];
      if (vv) begin
        pend[0] <= value;
        pend[1] <= value;
      end
      e[0] <= e[0] + 1;
      e[1] <= e[1] + 1;
    end
  end

  function automatic logic [28:0] exp_vec(input int i);
    int unsigned d, pp, q, f, h, v;
    logic pe, fs, hs, vs, act, sp;
    logic [7:0] c;
    logic [N-1:0] sv;
    d  = dv(i);
    sp = (i == 1);
    pe = (e[i] % d) == d - 1;
    pp = e[i] / d;
    fs = pe && ((pp % FRAME) == FRAME - 1);
    hs = ~sp;
    vs = ~sp;
    c  = 8'h00;
    act = 1'b0;
    if (pp != 0) begin
      q  = (pp - 1) % FRAME;
      f  = ((pp - 1) / FRAME) % 64;
      h  = q % HT;
      v  = q / HT;
      sv = fval[i][f];
      act = (h < HA) && (v < VA);
      hs = (h >= HA + HFP && h < HA + HFP + HS) ? sp : ~sp;
      vs = (v >= VA + VFP && v < VA + VFP + VS) ? sp : ~sp;
      if (act) c = sv[N - 1 - h / (HA / N)] ? 8'hFF : 8'h20;
    end
    return {pe, hs, vs, c, c, c, act, fs};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("stream_a", {3'b0, ifa.pix_en, ifa.hsync, ifa.vsync, ifa.red, ifa.green, ifa.blue,
                         ifa.active, ifa.frame_start}, {3'b0, exp_vec(0)});
      check("stream_b", {3'b0, ifb.pix_en, ifb.hsync, ifb.vsync, ifb.red, ifb.green, ifb.blue,
                         ifb.active, ifb.frame_start}, {3'b0, exp_vec(1)});
    end
  end

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ifa.frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: got timeout expected frame_start within 600 cycles");
    end
  endtask

  // Entered on the frame_start cycle; returns line 0 red of the following frame.
  task automatic after_fs_row(output logic [13:0][7:0] row);
    @(negedge clk);
    vv = 1'b0;
    check("fs_width", {31'b0, ifa.frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    row[0] = ifa.red;
    for (int k = 1; k < HT; k++) begin
      repeat (2) @(negedge clk);
      row[k] = ifa.red;
    end
  endtask

  task automatic strobe(input logic [N-1:0] val);
    @(negedge clk);
    value = val;
    vv = 1'b1;
    @(negedge clk);
    vv = 1'b0;
  endtask

  task automatic check_row(input string name, input logic [13:0][7:0] got, input logic [13:0][7:0] exp);
    for (int k = 0; k < HT; k++) begin
      check(name, {24'b0, got[k]}, {24'b0, exp[k]});
    end
  endtask

  typedef struct {
    logic [N-1:0]     val;
    logic [13:0][7:0] row;
  } vec_t;

  vec_t tbl [5];
  logic [13:0][7:0] row;
  bit ok;
  int unsigned t_prev;
  int unsigned t0;

  initial begin
    tbl[0] = '{4'b1010, 112'h000000000000_2020FFFF2020FFFF};
    tbl[1] = '{4'b0110, 112'h000000000000_2020FFFFFFFF2020};
    tbl[2] = '{4'b1000, 112'h000000000000_202020202020FFFF};
    tbl[3] = '{4'b0000, 112'h000000000000_2020202020202020};
    tbl[4] = '{4'b1111, 112'h000000000000_FFFFFFFFFFFFFFFF};

    #1 reset = 1'b1;
    #1;
    check("rst_hsync_a", {31'b0, ifa.hsync}, 32'd1);
    check("rst_vsync_a", {31'b0, ifa.vsync}, 32'd1);
    check("rst_rgb_a", {8'b0, ifa.red, ifa.green, ifa.blue}, 32'd0);
    check("rst_active_a", {31'b0, ifa.active}, 32'd0);
    check("rst_fs_a", {31'b0, ifa.frame_start}, 32'd0);
    check("rst_sync_b", {30'b0, ifb.hsync, ifb.vsync}, 32'd0);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("first_pix_en", {31'b0, ifa.pix_en}, 32'd1);
    check("pix_en_b_high", {31'b0, ifb.pix_en}, 32'd1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      strobe(tbl[i].val);
      wait_fs(ok);
      if (i > 0) check("fs_period", cyc - t_prev, 32'd196);
      t_prev = cyc;
      after_fs_row(row);
      check_row("row_px", row, tbl[i].row);
    end

    // Strobe coinciding with the reload: old pending (1111) shows first.
    wait_fs(ok);
    value = 4'b0001;
    vv = 1'b1;
    after_fs_row(row);
    check_row("coinc_old", row, 112'h000000000000_FFFFFFFFFFFFFFFF);
    wait_fs(ok);
    after_fs_row(row);
    check_row("coinc_new", row, 112'h000000000000_FFFF202020202020);

    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      value = N'($urandom);
      vv = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    vv = 1'b0;

    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = ifb.frame_start;
    end
    t0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = ifb.frame_start;
    end
    check("fs_period_b", cyc - t0, 32'd98);

    // Reset mid-line at (hcnt=5, vcnt=2) of the divide-by-2 instance.
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = ((e[0] / 2) % FRAME) == 2 * HT + 5;
    end
    check("reach_midline", {31'b0, ok}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_hsync_a", {31'b0, ifa.hsync}, 32'd1);
    check("async_vsync_a", {31'b0, ifa.vsync}, 32'd1);
    check("async_rgb_a", {8'b0, ifa.red, ifa.green, ifa.blue}, 32'd0);
    check("async_active_a", {31'b0, ifa.active}, 32'd0);
    check("async_sync_b", {30'b0, ifb.hsync, ifb.vsync}, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_pix_en", {31'b0, ifa.pix_en}, 32'd1);
    check("post_rst_red", {24'b0, ifa.red}, 32'd0);
    @(negedge clk);
    check("post_rst_grey", {24'b0, ifa.red}, 32'h20);
    check("post_rst_active", {31'b0, ifa.active}, 32'd1);
    repeat (250) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_reg_display.md
Name: vga_reg_display

Overview:
- Parametrised VGA timing generator that also renders an N-bit register value as N vertical bars.
- Runs on the 50 MHz board clock and sits in the demo top level beside the CPU.
- Displays the CPU output port on screen, with a tear-free update once per frame.
- Generalises fixed 640x480 timing to any resolution, pixel divide ratio and sync polarity.

Parameters:
- N, 8, width of displayed value and number of bars (H_ACTIVE must be divisible by N).
- CLK_DIV, 2, fastclk cycles per pixel (>=1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- fastclk  input  1  system clock, only clock in block.
- reset  input  1  asynchronous, active-high reset.
- value  input  N  value to display (e.g. CPU outport).
- value_valid  input  1  capture strobe for value.
- pix_en  output  1  pixel strobe, one fastclk wide.
- hsync  output  1  horizontal sync.
- vsync  output  1  vertical sync.
- red  output  8  red channel.
- green  output  8  green channel.
- blue  output  8  blue channel.
- active  output  1  high while the registered outputs show a visible pixel.
- frame_start  output  1  one-cycle pulse when the displayed value reloads.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Divider counter: div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1), combinational from div.
  - If CLK_DIV = 1, pix_en is constant high after reset.
- Counters hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1) advance only on pix_en.
  - hcnt wraps to 0; vcnt increments on the hcnt wrap.
  - vcnt wraps to 0 after V_TOTAL-1.
- Pipeline: on each pix_en cycle the output registers load from the current (hcnt, vcnt), and the counters advance on the same edge.
  - Latency is one fastclk from a counter state to its outputs.
  - Outputs hold between strobes.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~SYNC_POL.
- vsync: same rule using vcnt and the V_ parameters.
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Colour:
  - Bar index b = hcnt / (H_ACTIVE/N). Bar 0 is leftmost and shows bit N-1 (MSB first).
  - Active and bit set: red/green/blue = 8'hFF.
  - Active and bit clear: 8'h20 each.
  - Not active: 8'h00.
- Value path:
  - value_valid high loads pending <= value on any fastclk edge.
  - On the pix_en cycle with hcnt == H_TOTAL-1 and vcnt == V_TOTAL-1, shown <= pending and frame_start pulses high for that one fastclk.
  - Pixel (0,0) of the next frame therefore uses the new shown value.
  - If value_valid coincides with the load cycle, shown takes the old pending; the new value appears one frame later.
  - Repeated strobes within a frame: the last one wins.
- Reset (asynchronous, any time including mid-line):
  - div, hcnt, vcnt, pending, shown = 0.
  - hsync = vsync = ~SYNC_POL; rgb = 0; active = 0; frame_start = 0.
  - First pix_en comes CLK_DIV fastclk edges after reset release.

Test Plan:
- Small config throughout: N=4, CLK_DIV=2, H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7); frame = 196 fastclk cycles.
- Reset release, no stimulus -> pix_en every 2nd cycle; hsync low for exactly 2 pixels (hcnt 10,11) each line; vsync low for 1 line (vcnt 5); all active pixels rgb=20/20/20.
- value=4'b1010 with one value_valid mid-frame -> current frame still grey. frame_start pulses once at 196-cycle boundary. Next frame, hcnt 0-1 white, 2-3 grey, 4-5 white, 6-7 grey; blanking pixels 00.
- value_valid on the exact frame_start cycle with value=4'b0001 (pending was 4'b1111) -> next frame all white; the frame after shows only bar 3 white.
- SYNC_POL=1, CLK_DIV=1 -> pix_en stays high; hsync/vsync high only in sync windows; frame period 98 cycles.
- Assert reset mid-line (hcnt=5, vcnt=2), hold 3 cycles, release -> outputs at reset values immediately, without waiting for a clock edge. Counters restart from (0,0); shown=0, so the first frame is all grey.
